data_mem_responder: RTL and testbench

Data-memory target sitting behind the main control decoder's mem_read_en/mem_write_en outputs. It accepts one load or store request at a time over a valid/ready handshake and sizes the access by funct3 (byte, half, word; signed or unsigned load). After a programmable wait it returns a single-cycle response carrying the extended load data or an error flag. It is the responder end of the core's memory-access interface and lets the datapath be exercised against non-zero memory latency.

---
 rtl/data_mem_responder.sv | 213 +++++++++++++++++++++
 tb/tb_data_mem_responder.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Single-outstanding data-memory target. Accepts one load or
//               store over valid/ready, sizes it by funct3 (B/H/W, signed or
//               unsigned loads), waits WAIT_CYCLES and returns a one-cycle
//               response with extended load data or an error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        mem_read_en,
   input  logic        mem_write_en,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [2:0]  funct3,
   output logic        rsp_valid,
   output logic [31:0] rdata,
   output logic        rsp_err
);

   localparam int          IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int          WAIT_M1     = (WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0;
   localparam logic [3:0]  c_WAIT_INIT = 4'(WAIT_M1);
   localparam logic [31:0] c_DEPTH     = 32'(DEPTH_WORDS);
   localparam logic        c_NO_WAIT   = (WAIT_CYCLES == 0);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // FSM and captured request
   state_t      state_q;
   logic [3:0]  cnt_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [2:0]  funct3_q;
   logic        rd_q;
   logic        wr_q;

   // Registered response
   logic        rsp_valid_q;
   logic        rsp_err_q;
   logic [31:0] rdata_q;

   // Word storage, intentionally not reset
   logic [31:0] mem_q [DEPTH_WORDS];

   // Request fields as seen on the edge that enters RESP
   logic        w_accept;
   logic        w_enter_resp;
   logic [31:0] w_addr;
   logic [31:0] w_wdata;
   logic [2:0]  w_f3;
   logic        w_rd;
   logic        w_wr;

   logic        w_f3_bad;
   logic        w_misalign;
   logic        w_oor;
   logic        w_commit;
   logic [IDX_W-1:0] w_idx;
   logic [31:0] w_word;
   logic [31:0] w_shifted;
   logic [15:0] w_half;
   logic [3:0]  w_be;
   logic [31:0] w_lanes;
   logic [31:0] w_ext;
   logic        rsp_err_d;
   logic [31:0] rdata_d;

   assign req_ready = (state_q == ST_IDLE) && !rst;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rdata     = rdata_q;

   // With zero wait the accept edge is also the RESP-entry edge, so the
   // error check, load read and store commit must look at the live inputs.
   assign w_accept     = (state_q == ST_IDLE) && req_valid && (mem_read_en || mem_write_en);
   assign w_enter_resp = (w_accept && c_NO_WAIT) || ((state_q == ST_WAIT) && (cnt_q == 4'd0));
   assign w_addr       = (state_q == ST_IDLE) ? addr         : addr_q;
   assign w_wdata      = (state_q == ST_IDLE) ? wdata        : wdata_q;
   assign w_f3         = (state_q == ST_IDLE) ? funct3       : funct3_q;
   assign w_rd         = (state_q == ST_IDLE) ? mem_read_en  : rd_q;
   assign w_wr         = (state_q == ST_IDLE) ? mem_write_en : wr_q;

   // Rejection rules
   assign w_f3_bad   = (w_f3 == 3'b011) || (w_f3[2:1] == 2'b11);
   assign w_misalign = ((w_f3[1:0] == 2'b01) && w_addr[0]) ||
                       ((w_f3 == 3'b010) && (w_addr[1:0] != 2'b00));
   assign w_oor      = ({2'b00, w_addr[31:2]} >= c_DEPTH);
   assign rsp_err_d  = (w_rd && w_wr) || w_f3_bad || (w_wr && w_f3[2]) || w_misalign || w_oor;

   assign w_idx    = w_addr[IDX_W+1:2];
   assign w_word   = w_oor ? 32'd0 : mem_q[w_idx];
   assign w_commit = w_enter_resp && w_wr && !rsp_err_d && !rst;

   // Load lane selection and sign/zero extension
   always_comb begin
      w_shifted = w_word >> {w_addr[1:0], 3'b000};
      w_half    = w_addr[1] ? w_word[31:16] : w_word[15:0];
      w_ext     = 32'd0;
      case (w_f3)
         3'b000:  w_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};
         3'b001:  w_ext = {{16{w_half[15]}}, w_half};
         3'b010:  w_ext = w_word;
         3'b100:  w_ext = {24'd0, w_shifted[7:0]};
         3'b101:  w_ext = {16'd0, w_half};
         default: w_ext = 32'd0;
      endcase
      rdata_d = (w_rd && !rsp_err_d) ? w_ext : 32'd0;
   end

   // Store byte enables and data replicated into every lane
   always_comb begin
      w_be    = 4'b0000;
      w_lanes = w_wdata;
      case (w_f3[1:0])
         2'b00: begin
            w_be    = 4'b0001 << w_addr[1:0];
            w_lanes = {4{w_wdata[7:0]}};
         end
         2'b01: begin
            w_be    = w_addr[1] ? 4'b1100 : 4'b0011;
            w_lanes = {2{w_wdata[15:0]}};
         end
         2'b10: begin
            w_be    = 4'b1111;
            w_lanes = w_wdata;
         end
         default: begin
            w_be    = 4'b0000;
            w_lanes = w_wdata;
         end
      endcase
   end

   // Byte-enabled store commit on the RESP-entry edge
   always_ff @(posedge clk) begin
      if (w_commit) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) begin
               mem_q[w_idx][8*b +: 8] <= w_lanes[8*b +: 8];
            end
         end
      end
   end

   // Request FSM with registered one-cycle response
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         funct3_q    <= 3'd0;
         rd_q        <= 1'b0;
         wr_q        <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rdata_q     <= 32'd0;
      end else begin
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rdata_q     <= 32'd0;
         case (state_q)
            ST_IDLE: begin
               if (w_accept) begin
                  addr_q   <= addr;
                  wdata_q  <= wdata;
                  funct3_q <= funct3;
                  rd_q     <= mem_read_en;
                  wr_q     <= mem_write_en;
                  if (c_NO_WAIT) begin
                     state_q <= ST_RESP;
                  end else begin
                     state_q <= ST_WAIT;
                     cnt_q   <= c_WAIT_INIT;
                  end
               end
            end
            ST_WAIT: begin
               if (cnt_q == 4'd0) begin
                  state_q <= ST_RESP;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            ST_RESP: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
         if (w_enter_resp) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= rsp_err_d;
            rdata_q     <= rdata_d;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Bench for data_mem_responder. Three instances (wait 1, 0, 3)
//               share clock and reset; a byte-addressed reference model
//               predicts every cycle's outputs, and directed transfers pin
//               literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

   localparam int N     = 3;
   localparam int DEPTH = 256;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic [N-1:0]       req_valid = '0;
   logic [N-1:0]       rd_en     = '0;
   logic [N-1:0]       wr_en     = '0;
   logic [N-1:0][31:0] addr      = '0;
   logic [N-1:0][31:0] wdata     = '0;
   logic [N-1:0][2:0]  funct3    = '0;
   logic [N-1:0]       req_ready;
   logic [N-1:0]       rsp_valid;
   logic [N-1:0]       rsp_err;
   logic [N-1:0][31:0] rdata;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;
   int wait_cfg [N] = '{1, 0, 3};

   generate
      for (genvar g = 0; g < N; g++) begin : g_dut
         localparam int W = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
         data_mem_responder #(
            .DEPTH_WORDS(DEPTH),
            .WAIT_CYCLES(W)
         ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .req_valid   (req_valid[g]),
            .req_ready   (req_ready[g]),
            .mem_read_en (rd_en[g]),
            .mem_write_en(wr_en[g]),
            .addr        (addr[g]),
            .wdata       (wdata[g]),
            .funct3      (funct3[g]),
            .rsp_valid   (rsp_valid[g]),
            .rdata       (rdata[g]),
            .rsp_err     (rsp_err[g])
         );
      end
   endgenerate

   initial forever #5 clk = ~clk;

   // ---------------- reference model ----------------
   bit          m_busy  [N];
   int          m_cnt   [N];
   bit          m_rd    [N];
   bit          m_wr    [N];
   logic [31:0] m_addr  [N];
   logic [31:0] m_wdata [N];
   logic [2:0]  m_f3    [N];
   bit          e_err   [N];
   logic [31:0] e_rdata [N];
   bit          e_known [N];
   bit [7:0]    m_mem [longint];

   function automatic longint key(input int d, input logic [31:0] a);
      return longint'(d) * 64'h1_0000_0000 + longint'({32'd0, a});
   endfunction

   task automatic resolve(input int d);
      logic [2:0]  f;
      logic [31:0] a;
      int          size;
      bit          err;
      longint      v;
      f    = m_f3[d];
      a    = m_addr[d];
      size = (f[1:0] == 2'b00) ? 1 : ((f[1:0] == 2'b01) ? 2 : 4);
      err  = (m_rd[d] && m_wr[d]) || (f == 3'd3) || (f == 3'd6) || (f == 3'd7) ||
             (m_wr[d] && f[2]) || (size == 2 && (a % 2) != 0) ||
             (size == 4 && (a % 4) != 0) || ((a / 4) >= DEPTH);
      e_err[d]   = err;
      e_rdata[d] = 32'd0;
      e_known[d] = 1'b1;
      if (!err && m_wr[d]) begin
         for (int i = 0; i < size; i++)
            m_mem[key(d, a + i)] = 8'(m_wdata[d] >> (8 * i));
      end
      if (!err && m_rd[d]) begin
         v = 0;
         for (int i = 0; i < size; i++) begin
            if (m_mem.exists(key(d, a + i)))
               v = v + (longint'(m_mem[key(d, a + i)]) << (8 * i));
            else
               e_known[d] = 1'b0;
         end
         if (!f[2] && size < 4 && (((v >> (8 * size - 1)) & 1) == 1))
            v = v - (longint'(1) << (8 * size));
         e_rdata[d] = v[31:0];
      end
   endtask

   initial begin
      for (int d = 0; d < N; d++) begin
         m_busy[d] = 1'b0;
         m_cnt[d]  = 0;
      end
      forever begin
         @(posedge clk);
         for (int d = 0; d < N; d++) begin
            if (rst) begin
               m_busy[d] = 1'b0;
            end else if (!m_busy[d]) begin
               if (req_valid[d] && (rd_en[d] || wr_en[d])) begin
                  m_busy[d]  = 1'b1;
                  m_cnt[d]   = wait_cfg[d];
                  m_rd[d]    = rd_en[d];
                  m_wr[d]    = wr_en[d];
                  m_addr[d]  = addr[d];
                  m_wdata[d] = wdata[d];
                  m_f3[d]    = funct3[d];
                  if (m_cnt[d] == 0) resolve(d);
               end
            end else if (m_cnt[d] == 0) begin
               m_busy[d] = 1'b0;
            end else begin
               m_cnt[d] = m_cnt[d] - 1;
               if (m_cnt[d] == 0) resolve(d);
            end
         end
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d actual=%h required=%h t=%0t", name, d, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of every instance against the model
   initial forever begin
      bit          ev;
      logic [31:0] exp_d;
      @(negedge clk);
      if (chk_en) begin
         for (int d = 0; d < N; d++) begin
            ev    = m_busy[d] && (m_cnt[d] == 0);
            exp_d = ev ? e_rdata[d] : 32'd0;
            chk("cyc_ready", d, 32'(req_ready[d]), 32'(!m_busy[d] && !rst));
            chk("cyc_rsp_valid", d, 32'(rsp_valid[d]), 32'(ev));
            chk("cyc_rsp_err", d, 32'(rsp_err[d]), 32'(ev && e_err[d]));
            if (!(ev && !e_known[d]))
               chk("cyc_rdata", d, rdata[d], exp_d);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // One request with handshake, latency and literal response checks
   task automatic xfer(input int d, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [2:0] f3,
                       input logic [31:0] exp_data, input bit exp_err);
      bit acc;
      bit seen;
      int guard;
      int lat;
      @(posedge clk);
      #2;
      rd_en[d]     = rd;
      wr_en[d]     = wr;
      addr[d]      = a;
      wdata[d]     = wd;
      funct3[d]    = f3;
      req_valid[d] = 1'b1;
      acc   = 1'b0;
      guard = 0;
      while (!acc && guard < 50) begin
         @(negedge clk);
         acc = req_ready[d];
         @(posedge clk);
         guard++;
      end
      #2;
      req_valid[d] = 1'b0;
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL accept dut%0d actual=no_ready required=ready_within_%0d", d, guard);
      end else begin
         seen = 1'b0;
         lat  = 0;
         while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            seen = rsp_valid[d];
         end
         chk("rsp_seen", d, 32'(seen), 32'd1);
         if (seen) begin
            chk("latency", d, 32'(lat), 32'(wait_cfg[d] + 1));
            chk("rsp_err", d, 32'(rsp_err[d]), 32'(exp_err));
            chk("rdata", d, rdata[d], exp_data);
         end
      end
   endtask

   initial begin
      // reset state
      @(posedge clk);
      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < N; d++) begin
         chk("rst_ready", d, 32'(req_ready[d]), 32'd0);
         chk("rst_rsp_valid", d, 32'(rsp_valid[d]), 32'd0);
         chk("rst_rdata", d, rdata[d], 32'd0);
         chk("rst_err", d, 32'(rsp_err[d]), 32'd0);
      end
      @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      for (int d = 0; d < N; d++) chk("idle_ready", d, 32'(req_ready[d]), 32'd1);

      // wait=1 instance: stores and sized loads
      xfer(0, 0, 1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 0);
      xfer(0, 1, 0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 0);
      xfer(0, 1, 0, 32'h13, 32'h0, 3'b000, 32'hFFFFFFDE, 0);
      xfer(0, 1, 0, 32'h13, 32'h0, 3'b100, 32'h000000DE, 0);
      xfer(0, 1, 0, 32'h10, 32'h0, 3'b001, 32'hFFFFBEEF, 0);
      xfer(0, 1, 0, 32'h12, 32'h0, 3'b101, 32'h0000DEAD, 0);
      xfer(0, 0, 1, 32'h11, 32'h000000AA, 3'b000, 32'h0, 0);
      xfer(0, 1, 0, 32'h10, 32'h0, 3'b010, 32'hDEADAAEF, 0);
      xfer(0, 0, 1, 32'h12, 32'h00001234, 3'b001, 32'h0, 0);
      xfer(0, 1, 0, 32'h10, 32'h0, 3'b010, 32'h1234AAEF, 0);

      // rejected requests
      xfer(0, 1, 0, 32'h12, 32'h0, 3'b010, 32'h0, 1);
      xfer(0, 0, 1, 32'h11, 32'h0000FFFF, 3'b001, 32'h0, 1);
      xfer(0, 0, 1, 32'h10, 32'h00000077, 3'b100, 32'h0, 1);
      xfer(0, 1, 1, 32'h10, 32'h00000000, 3'b010, 32'h0, 1);
      xfer(0, 1, 0, 32'(4 * DEPTH), 32'h0, 3'b010, 32'h0, 1);
      xfer(0, 1, 0, 32'h10, 32'h0, 3'b010, 32'h1234AAEF, 0);

      // valid with neither enable is ignored
      @(posedge clk);
      #2;
      rd_en[0] = 1'b0;
      wr_en[0] = 1'b0;
      req_valid[0] = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("ignored_ready", 0, 32'(req_ready[0]), 32'd1);
      chk("ignored_rsp", 0, 32'(rsp_valid[0]), 32'd0);
      @(posedge clk);
      #2 req_valid[0] = 1'b0;

      // wait=0 instance: back-to-back loads with valid held high
      xfer(1, 0, 1, 32'h40, 32'h0A0B0C0D, 3'b010, 32'h0, 0);
      xfer(1, 0, 1, 32'h44, 32'hCAFEF00D, 3'b010, 32'h0, 0);
      @(posedge clk);
      #2;
      rd_en[1] = 1'b1;
      wr_en[1] = 1'b0;
      addr[1] = 32'h40;
      funct3[1] = 3'b010;
      req_valid[1] = 1'b1;
      @(negedge clk);
      chk("b2b_ready0", 1, 32'(req_ready[1]), 32'd1);
      @(posedge clk);
      #2 addr[1] = 32'h44;
      @(negedge clk);
      chk("b2b_rsp0", 1, 32'(rsp_valid[1]), 32'd1);
      chk("b2b_data0", 1, rdata[1], 32'h0A0B0C0D);
      @(negedge clk);
      chk("b2b_gap_rsp", 1, 32'(rsp_valid[1]), 32'd0);
      chk("b2b_gap_ready", 1, 32'(req_ready[1]), 32'd1);
      @(negedge clk);
      chk("b2b_rsp1", 1, 32'(rsp_valid[1]), 32'd1);
      chk("b2b_data1", 1, rdata[1], 32'hCAFEF00D);
      @(posedge clk);
      #2 req_valid[1] = 1'b0;

      // wait=3 instance: reset during a store's second wait cycle
      xfer(2, 0, 1, 32'h20, 32'h11223344, 3'b010, 32'h0, 0);
      @(posedge clk);
      #2;
      rd_en[2] = 1'b0;
      wr_en[2] = 1'b1;
      addr[2] = 32'h20;
      wdata[2] = 32'h00000055;
      funct3[2] = 3'b010;
      req_valid[2] = 1'b1;
      @(negedge clk);
      chk("abort_ready", 2, 32'(req_ready[2]), 32'd1);
      @(posedge clk);
      #2 req_valid[2] = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", 2, 32'(req_ready[2]), 32'd1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("no_rsp_after_abort", 2, 32'(rsp_valid[2]), 32'd0);
      end
      xfer(2, 1, 0, 32'h20, 32'h0, 3'b010, 32'h11223344, 0);

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
